alu_issue_ctrl: RTL and testbench

Execute-stage requester for the RV32I ALU. It accepts an operation request (ALUOp, funct3, funct7[5], two operands) over a valid/ready handshake and decodes it into the 4-bit ALU control code. It drives registered operands and control into the ALU, captures the ALU result and zero flag, and returns them with a branch-taken decision over a second valid/ready handshake. It is the other end of the ALU's A/B/Control_in/ALU_Result/zero interface.

---
 rtl/alu_issue_ctrl_if.sv | 44 ++++
 rtl/alu_issue_ctrl.sv | 133 +++++++++++++
 tb/tb_alu_issue_ctrl.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_ctrl_if.sv
// Request / ALU / response bundle between an execute-stage requester and
// the alu_issue_ctrl block. The slave view is the controller itself; the
// master view is whoever issues requests, consumes responses and hosts the ALU.
interface alu_issue_ctrl_if #(parameter int XLEN = 32);
    // request channel
    logic            req_valid;
    logic            req_ready;
    logic [1:0]      req_alu_op;
    logic [2:0]      req_funct3;
    logic            req_funct7b5;
    logic [XLEN-1:0] req_a;
    logic [XLEN-1:0] req_b;
    // ALU side
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [3:0]      alu_control;
    logic [XLEN-1:0] alu_result;
    logic            alu_zero;
    // response channel
    logic            rsp_valid;
    logic            rsp_ready;
    logic [XLEN-1:0] rsp_result;
    logic            rsp_zero;
    logic            rsp_branch_taken;
    logic            rsp_illegal;

    modport slave (
        input  req_valid, req_alu_op, req_funct3, req_funct7b5, req_a, req_b,
        output req_ready,
        output alu_a, alu_b, alu_control,
        input  alu_result, alu_zero,
        output rsp_valid, rsp_result, rsp_zero, rsp_branch_taken, rsp_illegal,
        input  rsp_ready
    );

    modport master (
        output req_valid, req_alu_op, req_funct3, req_funct7b5, req_a, req_b,
        input  req_ready,
        input  alu_a, alu_b, alu_control,
        output alu_result, alu_zero,
        input  rsp_valid, rsp_result, rsp_zero, rsp_branch_taken, rsp_illegal,
        output rsp_ready
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Execute-stage ALU requester: decodes an ALUOp/funct request into the ALU
// control code, holds operands at the ALU for one cycle, captures the result
// and zero flag, and returns them with a branch decision.
module alu_issue_ctrl #(
    parameter int XLEN = 32
) (
    input  logic             clk,
    input  logic             reset,
    alu_issue_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    typedef enum logic [1:0] {BR_NONE, BR_EQ, BR_NE} br_t;

    localparam logic [3:0] CODE_AND = 4'b0000;
    localparam logic [3:0] CODE_OR  = 4'b0001;
    localparam logic [3:0] CODE_ADD = 4'b0010;
    localparam logic [3:0] CODE_SUB = 4'b0110;

    state_t          state_reg, state_next;
    logic [XLEN-1:0] alu_a_reg, alu_b_reg;
    logic [3:0]      alu_control_reg;
    br_t             br_reg;
    logic            illegal_reg;
    logic [XLEN-1:0] rsp_result_reg;
    logic            rsp_zero_reg, rsp_taken_reg, rsp_illegal_reg;

    logic [3:0]      dec_code;
    logic            dec_illegal;
    br_t             dec_br;
    logic            accept, capture, taken_next;

    // Decode the request fields into an ALU code, branch kind and illegal flag
    always_comb begin
        dec_code    = CODE_ADD;
        dec_illegal = 1'b0;
        dec_br      = BR_NONE;
        case (bus.req_alu_op)
            2'b00: dec_code = CODE_ADD;
            2'b01: begin
                dec_code = CODE_SUB;
                case (bus.req_funct3)
                    3'b000:  dec_br = BR_EQ;
                    3'b001:  dec_br = BR_NE;
                    default: dec_illegal = 1'b1;
                endcase
            end
            2'b10: begin
                case (bus.req_funct3)
                    3'b000:  dec_code = bus.req_funct7b5 ? CODE_SUB : CODE_ADD;
                    3'b111:  dec_code = CODE_AND;
                    3'b110:  dec_code = CODE_OR;
                    default: dec_illegal = 1'b1;
                endcase
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    // Ready only while idle and out of reset, so a request can never be
    // taken in the same cycle a response completes.
    assign bus.req_ready = (state_reg == IDLE) && !reset;
    assign bus.rsp_valid = (state_reg == RESP);
    assign accept        = bus.req_valid && bus.req_ready;

    // Next-state logic and the strobes that qualify the datapath registers
    always_comb begin
        state_next = state_reg;
        capture    = 1'b0;
        taken_next = 1'b0;
        case (state_reg)
            IDLE: if (accept) state_next = EXEC;
            EXEC: begin
                state_next = RESP;
                capture    = 1'b1;
            end
            RESP: if (bus.rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (!illegal_reg) begin
            if (br_reg == BR_EQ)      taken_next = bus.alu_zero;
            else if (br_reg == BR_NE) taken_next = !bus.alu_zero;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    // Operand/control hold registers, loaded only on request accept
    always_ff @(posedge clk) begin
        if (reset) begin
            alu_a_reg       <= '0;
            alu_b_reg       <= '0;
            alu_control_reg <= CODE_ADD;
            br_reg          <= BR_NONE;
            illegal_reg     <= 1'b0;
        end else if (accept) begin
            alu_a_reg       <= bus.req_a;
            alu_b_reg       <= bus.req_b;
            alu_control_reg <= dec_code;
            br_reg          <= dec_br;
            illegal_reg     <= dec_illegal;
        end
    end

    // Response registers, captured from the ALU at the end of EXEC and held
    // until the next operation reaches that point
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_result_reg  <= '0;
            rsp_zero_reg    <= 1'b0;
            rsp_taken_reg   <= 1'b0;
            rsp_illegal_reg <= 1'b0;
        end else if (capture) begin
            rsp_result_reg  <= bus.alu_result;
            rsp_zero_reg    <= bus.alu_zero;
            rsp_taken_reg   <= taken_next;
            rsp_illegal_reg <= illegal_reg;
        end
    end

    assign bus.alu_a            = alu_a_reg;
    assign bus.alu_b            = alu_b_reg;
    assign bus.alu_control      = alu_control_reg;
    assign bus.rsp_result       = rsp_result_reg;
    assign bus.rsp_zero         = rsp_zero_reg;
    assign bus.rsp_branch_taken = rsp_taken_reg;
    assign bus.rsp_illegal      = rsp_illegal_reg;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural RV32I ALU attached.
module tb_alu_issue_ctrl;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    alu_issue_ctrl_if #(.XLEN(32)) bus ();

    alu_issue_ctrl #(.XLEN(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: zero flag is produced only for subtraction
    always_comb begin
        case (bus.alu_control)
            4'b0000: bus.alu_result = bus.alu_a & bus.alu_b;
            4'b0001: bus.alu_result = bus.alu_a | bus.alu_b;
            4'b0010: bus.alu_result = bus.alu_a + bus.alu_b;
            4'b0110: bus.alu_result = bus.alu_a - bus.alu_b;
            default: bus.alu_result = 32'h0;
        endcase
        bus.alu_zero = (bus.alu_control == 4'b0110) && (bus.alu_result == 32'h0);
    end

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        n_tests++;
        if (observed !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end else begin
            $display("ok   %s: 0x%08h", tag, observed);
        end
    endtask

    // Present a request and return #1 after the accepting edge (state EXEC)
    task automatic issue(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                         input logic [31:0] a, input logic [31:0] b);
        int waited;
        @(negedge clk);
        bus.req_alu_op   = op;
        bus.req_funct3   = f3;
        bus.req_funct7b5 = f7;
        bus.req_a        = a;
        bus.req_b        = b;
        bus.req_valid    = 1'b1;
        waited = 0;
        while (!bus.req_ready && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.req_ready) check("req_ready_timeout", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    // Complete the pending response handshake and confirm return to IDLE
    task automatic drain(input string tag);
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_valid_drop"}, 32'(bus.rsp_valid), 32'd0);
        check({tag, "_req_ready"},  32'(bus.req_ready), 32'd1);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] held;
        n_tests = 0;
        n_fail  = 0;
        reset            = 1'b1;
        bus.req_valid    = 1'b0;
        bus.req_alu_op   = 2'b00;
        bus.req_funct3   = 3'b000;
        bus.req_funct7b5 = 1'b0;
        bus.req_a        = 32'h0;
        bus.req_b        = 32'h0;
        bus.rsp_ready    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_alu_a",   bus.alu_a, 32'h0);
        check("rst_alu_b",   bus.alu_b, 32'h0);
        check("rst_ctrl",    32'(bus.alu_control), 32'h2);
        check("rst_valid",   32'(bus.rsp_valid), 32'd0);
        check("rst_ready",   32'(bus.req_ready), 32'd0);
        check("rst_result",  bus.rsp_result, 32'h0);
        check("rst_illegal", 32'(bus.rsp_illegal), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("idle_ready", 32'(bus.req_ready), 32'd1);

        // 1: R-type ADD wraps to zero
        issue(2'b10, 3'b000, 1'b0, 32'hFFFF_FFFF, 32'h1);
        check("add_ctrl",       32'(bus.alu_control), 32'h2);
        check("add_exec_valid", 32'(bus.rsp_valid), 32'd0);
        check("add_exec_ready", 32'(bus.req_ready), 32'd0);
        @(posedge clk); #1;
        check("add_valid",   32'(bus.rsp_valid), 32'd1);
        check("add_result",  bus.rsp_result, 32'h0);
        check("add_illegal", 32'(bus.rsp_illegal), 32'd0);
        drain("add");

        // 2: BEQ then BNE with equal operands
        issue(2'b01, 3'b000, 1'b0, 32'h1234, 32'h1234);
        check("beq_ctrl", 32'(bus.alu_control), 32'h6);
        @(posedge clk); #1;
        check("beq_zero",  32'(bus.rsp_zero), 32'd1);
        check("beq_taken", 32'(bus.rsp_branch_taken), 32'd1);
        drain("beq");
        check("beq_taken_hold", 32'(bus.rsp_branch_taken), 32'd1);
        issue(2'b01, 3'b001, 1'b0, 32'h1234, 32'h1234);
        @(posedge clk); #1;
        check("bne_zero",  32'(bus.rsp_zero), 32'd1);
        check("bne_taken", 32'(bus.rsp_branch_taken), 32'd0);
        drain("bne");
        issue(2'b01, 3'b001, 1'b0, 32'h1234, 32'h1235);
        @(posedge clk); #1;
        check("bne_ne_taken", 32'(bus.rsp_branch_taken), 32'd1);
        drain("bne_ne");

        // 3: AND / OR, then R-type SUB
        issue(2'b10, 3'b111, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00);
        check("and_ctrl", 32'(bus.alu_control), 32'h0);
        @(posedge clk); #1;
        check("and_result", bus.rsp_result, 32'hF000_F000);
        drain("and");
        issue(2'b10, 3'b000, 1'b1, 32'h10, 32'h3);
        check("sub_ctrl", 32'(bus.alu_control), 32'h6);
        @(posedge clk); #1;
        check("sub_result", bus.rsp_result, 32'hD);
        check("sub_taken",  32'(bus.rsp_branch_taken), 32'd0);
        drain("sub");

        // 4: OR with five cycles of backpressure
        issue(2'b10, 3'b110, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00);
        check("or_ctrl", 32'(bus.alu_control), 32'h1);
        @(posedge clk); #1;
        check("or_result", bus.rsp_result, 32'hFFF0_FFF0);
        held = bus.rsp_result;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_valid",  32'(bus.rsp_valid), 32'd1);
            check("bp_ready",  32'(bus.req_ready), 32'd0);
            check("bp_result", bus.rsp_result, 32'hFFF0_FFF0);
        end
        drain("bp");
        check("bp_result_after", bus.rsp_result, held);

        // 5: illegal requests; the taken flag must stay low even when operands match
        issue(2'b01, 3'b000, 1'b0, 32'h5, 32'h5);
        @(posedge clk); #1;
        check("pre_ill_taken", 32'(bus.rsp_branch_taken), 32'd1);
        drain("pre_ill");
        issue(2'b11, 3'b000, 1'b0, 32'h5, 32'h5);
        check("op11_ctrl", 32'(bus.alu_control), 32'h2);
        @(posedge clk); #1;
        check("op11_illegal", 32'(bus.rsp_illegal), 32'd1);
        check("op11_taken",   32'(bus.rsp_branch_taken), 32'd0);
        drain("op11");
        issue(2'b10, 3'b100, 1'b0, 32'h5, 32'h6);
        check("f3_100_ctrl", 32'(bus.alu_control), 32'h2);
        @(posedge clk); #1;
        check("f3_100_illegal", 32'(bus.rsp_illegal), 32'd1);
        drain("f3_100");
        issue(2'b01, 3'b010, 1'b0, 32'h7, 32'h7);
        @(posedge clk); #1;
        check("br010_illegal", 32'(bus.rsp_illegal), 32'd1);
        check("br010_taken",   32'(bus.rsp_branch_taken), 32'd0);
        drain("br010");
        issue(2'b00, 3'b010, 1'b0, 32'h100, 32'h20);
        @(posedge clk); #1;
        check("ldst_result",  bus.rsp_result, 32'h120);
        check("ldst_illegal", 32'(bus.rsp_illegal), 32'd0);
        drain("ldst");

        // 6: reset during EXEC, with a request held valid through the reset cycle
        issue(2'b10, 3'b000, 1'b0, 32'h5, 32'h6);
        reset         = 1'b1;
        bus.req_valid = 1'b1;
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_valid",  32'(bus.rsp_valid), 32'd0);
        check("mid_rst_alu_a",  bus.alu_a, 32'h0);
        check("mid_rst_ctrl",   32'(bus.alu_control), 32'h2);
        check("mid_rst_result", bus.rsp_result, 32'h0);
        @(negedge clk);
        reset         = 1'b0;
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        @(posedge clk); #1;
        check("post_rst_valid", 32'(bus.rsp_valid), 32'd0);
        check("post_rst_alu_a", bus.alu_a, 32'h0);
        issue(2'b10, 3'b000, 1'b0, 32'h3, 32'h4);
        @(posedge clk); #1;
        check("post_rst_add", bus.rsp_result, 32'h7);
        drain("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
